// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared funct3 encodings, responder FSM states and access-size helpers
package pipeline_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int LANE_BITS = 2;
  localparam int BYTE_W    = 8;
  localparam int HALF_W    = 16;
  // Anything that is not a recognised byte/halfword encoding behaves as a word access.
  function automatic size_t f3_size(input logic [2:0] f3, input logic wr);
    return (f3 == F3_B || (!wr && f3 == F3_BU)) ? SZ_B :
           (f3 == F3_H || (!wr && f3 == F3_HU)) ? SZ_H : SZ_W;
  endfunction
  function automatic logic f3_unsigned(input logic [2:0] f3);
    return f3 == F3_BU || f3 == F3_HU;
  endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: picks the addressed byte/halfword lane from a word and sign/zero extends it
module load_extend
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            lane,
  input  logic [1:0]            size,
  input  logic                  uns,
  output logic [DATA_WIDTH-1:0] data
);
  logic [BYTE_W-1:0] b;
  logic [HALF_W-1:0] h;
  // Lane select then extend to full width; word accesses pass through untouched.
  always_comb begin
    b    = word[{lane, 3'b000} +: BYTE_W];
    h    = word[{lane[1], 4'b0000} +: HALF_W];
    data = size == SZ_B ? {{(DATA_WIDTH-BYTE_W){b[BYTE_W-1] & ~uns}}, b} :
           size == SZ_H ? {{(DATA_WIDTH-HALF_W){h[HALF_W-1] & ~uns}}, h} : word;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory with stall handshake; define MISALIGN_TRAP_EN to trap misaligned accesses
module data_mem_responder
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReqM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  MemStallM,
  output logic                  MisalignM
);
  localparam int ADDR_BITS = $clog2(DEPTH_WORDS);
  localparam int NB = DATA_WIDTH / 8;
  state_t state, next;
  logic [3:0] cnt;
  logic wr_q;
  logic [2:0] f3_q;
  logic [ADDR_BITS+1:0] addr_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  size_t size;
  logic [1:0] lane;
  logic mis, commit, uns;
  logic [NB-1:0] be;
  logic [DATA_WIDTH-1:0] wdata, ld;
  logic [ADDR_BITS-1:0] idx;
  logic unused_addr;
  assign unused_addr = ^ALUResultM[DATA_WIDTH-1:ADDR_BITS+2];
  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // Accept only in IDLE, leave BUSY when the wait counter has run out, DONE lasts one cycle.
  always_comb
    next = state == IDLE ? (MemReqM ? BUSY : IDLE) :
           state == BUSY ? (cnt == 4'd0 ? DONE : BUSY) : IDLE;
  // Capture the request on acceptance so later input changes cannot disturb it; count down while busy.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      wr_q   <= 1'b0;
      f3_q   <= '0;
      addr_q <= '0;
      wd_q   <= '0;
    end else if (state == IDLE && MemReqM) begin
      cnt    <= 4'(WAIT_CYCLES);
      wr_q   <= MemWriteM;
      f3_q   <= Funct3M;
      addr_q <= ALUResultM[ADDR_BITS+1:0];
      wd_q   <= WriteDataM;
    end else if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
  // Decode the captured request into word index, lane, byte enables and replicated store data.
  always_comb begin
    size  = f3_size(f3_q, wr_q);
    uns   = f3_unsigned(f3_q);
    idx   = addr_q[ADDR_BITS+1:2];
`ifdef MISALIGN_TRAP_EN
    mis   = (size == SZ_H && addr_q[0]) || (size == SZ_W && addr_q[1:0] != 2'b00);
    lane  = addr_q[1:0];
`else
    mis   = 1'b0;
    lane  = size == SZ_B ? addr_q[1:0] : size == SZ_H ? {addr_q[1], 1'b0} : 2'b00;
`endif
    be     = size == SZ_B ? NB'(1) << lane : size == SZ_H ? NB'(3) << lane : '1;
    wdata  = size == SZ_B ? {NB{wd_q[7:0]}} : size == SZ_H ? {(NB/2){wd_q[15:0]}} : wd_q;
    commit = state == BUSY && cnt == 4'd0 && wr_q && !mis;
  end
  // Store commits on the BUSY->DONE edge; the array itself is never reset.
  always_ff @(posedge clk)
    for (int i = 0; i < NB; i++)
      if (commit && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
    .word (mem[idx]),
    .lane (lane),
    .size (size),
    .uns  (uns),
    .data (ld)
  );
  // Stall while a request is being accepted or serviced; load data and trap flag only in DONE.
  always_comb begin
    MemStallM = (state == IDLE && MemReqM) || state == BUSY;
    MisalignM = state == DONE && mis;
    RD        = (state == DONE && !wr_q && !mis) ? ld : '0;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for two responders (WAIT_CYCLES=2 and 0)
module tb_data_mem_responder;
  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          stall;
  } exp_t;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n [2];
  logic req [2], wr [2], stall [2], mis [2];
  logic [2:0] f3 [2];
  logic [31:0] addr [2], wd [2], rd [2];
  exp_t q0 [$], q1 [$];
  logic prev [2];
  int scnt [2];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_CYCLES(2)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .MemReqM(req[0]), .MemWriteM(wr[0]), .Funct3M(f3[0]),
    .ALUResultM(addr[0]), .WriteDataM(wd[0]), .RD(rd[0]), .MemStallM(stall[0]), .MisalignM(mis[0])
  );
  data_mem_responder #(.WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .MemReqM(req[1]), .MemWriteM(wr[1]), .Funct3M(f3[1]),
    .ALUResultM(addr[1]), .WriteDataM(wd[1]), .RD(rd[1]), .MemStallM(stall[1]), .MisalignM(mis[1])
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  task automatic mon(input int i);
    exp_t e;
    if (!rst_n[i]) begin
      prev[i] = 1'b0;
      scnt[i] = 0;
    end else if (stall[i]) begin
      scnt[i]++;
      prev[i] = 1'b1;
      chk($sformatf("rd_zero_stalled%0d", i), rd[i], 32'h0);
    end else if (prev[i]) begin
      prev[i] = 1'b0;
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done%0d: got a DONE cycle, expected none", i);
      end else begin
        if (i == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("done_rd%0d", i), rd[i], e.rd);
        chk($sformatf("done_mis%0d", i), 32'(mis[i]), 32'(e.mis));
        chk($sformatf("stall_len%0d", i), scnt[i], e.stall);
      end
      scnt[i] = 0;
    end else begin
      chk($sformatf("rd_zero_idle%0d", i), rd[i], 32'h0);
      chk($sformatf("mis_zero_idle%0d", i), 32'(mis[i]), 32'h0);
    end
  endtask

  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);

  task automatic access(input int i, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_mis);
    int wc;
    wc = i == 0 ? 2 : 0;
    req[i] = 1'b1; wr[i] = w; f3[i] = f; addr[i] = a; wd[i] = d;
    if (i == 0) q0.push_back('{exp_rd, exp_mis, wc + 2});
    else q1.push_back('{exp_rd, exp_mis, wc + 2});
    @(posedge clk); #1;
    req[i] = 1'b0; wr[i] = ~w; f3[i] = 3'b000; addr[i] = ~a; wd[i] = ~d;
    repeat (wc + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; wr[i] = 1'b0; f3[i] = '0; addr[i] = '0; wd[i] = '0;
      prev[i] = 1'b0; scnt[i] = 0;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_stall%0d", i), 32'(stall[i]), 32'h0);
      chk($sformatf("reset_rd%0d", i), rd[i], 32'h0);
      chk($sformatf("reset_mis%0d", i), 32'(mis[i]), 32'h0);
    end
    req[0] = 1'b1;
    #1 chk("reset_stall_follows_req", 32'(stall[0]), 32'h1);
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    access(0, 1'b1, SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access(0, 1'b0, LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    access(0, 1'b1, SB, 32'h13, 32'h00000080, 32'h0, 1'b0);
    access(0, 1'b0, LB, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    access(0, 1'b0, LBU, 32'h13, 32'h0, 32'h00000080, 1'b0);
    access(0, 1'b0, LW, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    access(0, 1'b0, LH, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0);
    access(0, 1'b0, LHU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    access(0, 1'b0, LB, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
    access(0, 1'b0, 3'b011, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    access(0, 1'b0, LW, 32'h1010, 32'h0, 32'h80ADBEEF, 1'b0);
    access(0, 1'b1, 3'b111, 32'h30, 32'hA5A55A5A, 32'h0, 1'b0);
    access(0, 1'b0, LW, 32'h30, 32'h0, 32'hA5A55A5A, 1'b0);
    access(0, 1'b0, LW, 32'h12, 32'h0, TRAP ? 32'h0 : 32'h80ADBEEF, TRAP);
    access(0, 1'b1, SW, 32'h20, 32'h55AA1234, 32'h0, 1'b0);
    req[0] = 1'b1; wr[0] = 1'b1; f3[0] = SW; addr[0] = 32'h20; wd[0] = 32'h1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b0;
    #1;
    chk("abort_stall", 32'(stall[0]), 32'h0);
    chk("abort_rd", rd[0], 32'h0);
    chk("abort_mis", 32'(mis[0]), 32'h0);
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    access(0, 1'b0, LW, 32'h20, 32'h0, 32'h55AA1234, 1'b0);
    access(0, 1'b1, SH, 32'h21, 32'h0000BEEF, 32'h0, TRAP);
    access(0, 1'b0, LW, 32'h20, 32'h0, TRAP ? 32'h55AA1234 : 32'h55AABEEF, 1'b0);
    access(1, 1'b1, SW, 32'h0, 32'h12345678, 32'h0, 1'b0);
    access(1, 1'b0, LW, 32'h0, 32'h0, 32'h12345678, 1'b0);
    access(1, 1'b0, LW, 32'h0, 32'h0, 32'h12345678, 1'b0);
    access(1, 1'b1, SW, 32'h4, 32'hCAFEF00D, 32'h0, 1'b0);
    access(1, 1'b0, LW, 32'h4, 32'h0, 32'hCAFEF00D, 1'b0);
    access(1, 1'b0, LW, 32'h0, 32'h0, 32'h12345678, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data and address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of words in the internal array.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, range 0..15: extra busy cycles per access.
REQ-004 SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- MemReqM  in  1  memory-stage load/store request valid.
- MemWriteM  in  1  1 = store, 0 = load.
- Funct3M  in  3  access size/sign (RV32I LB/LH/LW/LBU/LHU, SB/SH/SW).
- ALUResultM  in  DATA_WIDTH  byte address.
- WriteDataM  in  DATA_WIDTH  store data, right-aligned.
- RD  out  DATA_WIDTH  load data, extended, toward the MEM/WB register.
- MemStallM  out  1  holds the pipeline while an access is outstanding.
- MisalignM  out  1  misaligned-access flag.

Function
REQ-005 SHALL implement a 3-state FSM: IDLE, BUSY, DONE.
REQ-006 IDLE with MemReqM=1 SHALL capture MemWriteM, Funct3M, ALUResultM and WriteDataM, load the counter with WAIT_CYCLES, and go to BUSY.
REQ-007 BUSY SHALL decrement the counter each cycle and go to DONE on the cycle the counter equals 0.
REQ-008 DONE SHALL go unconditionally to IDLE.
REQ-009 MemStallM SHALL be combinational: 1 when (IDLE and MemReqM) or BUSY, otherwise 0.
REQ-010 A request SHALL therefore see MemStallM=1 for WAIT_CYCLES+2 cycles, with MemStallM=0 in DONE.
REQ-011 Stores SHALL commit on the BUSY->DONE edge using only the captured request fields: SB writes one byte lane, SH two lanes, SW all four.
REQ-012 RD SHALL be valid throughout DONE and SHALL be 0 in all other states.
- Lane selection uses captured address bits [1:0].
- LB/LH sign-extend; LBU/LHU zero-extend.
REQ-013 A store in DONE SHALL drive RD=0.
REQ-014 The word index SHALL be address[ADDR_BITS+1:2], where ADDR_BITS = clog2(DEPTH_WORDS); upper address bits SHALL wrap silently.
REQ-015 Changes on MemReqM or any input during BUSY/DONE SHALL be ignored; a new request is accepted only in IDLE.
REQ-016 An unsupported Funct3M SHALL be treated as LW/SW.

Reset
REQ-017 rst_n low SHALL immediately force IDLE, counter=0, RD=0, MemStallM=0 (unless MemReqM), MisalignM=0.
REQ-018 Reset during BUSY SHALL abort the access with no write to the array.
REQ-019 The array contents SHALL NOT be reset.

Configuration
REQ-020 Macro MISALIGN_TRAP_EN defined: a halfword at odd address or a word with address[1:0]!=0 SHALL assert MisalignM for exactly the DONE cycle, suppress the store, and force RD=0.
REQ-021 Macro MISALIGN_TRAP_EN undefined: MisalignM SHALL be tied 0, and the address SHALL be aligned down to the access size before lane selection.

Structure
REQ-022 A shared package pipeline_pkg SHALL hold:
- Funct3 load/store encodings.
- The FSM state enum (IDLE/BUSY/DONE).
- The lane/size helper constants.
REQ-023 Lane extraction and sign/zero extension SHALL live in a combinational sub-module load_extend; FSM, counter and array SHALL stay in data_mem_responder.

Verification
REQ-024 The bench SHALL cover these directed scenarios (WAIT_CYCLES=2 unless stated):
- SW 0xDEADBEEF to 0x10, then LW 0x10 -> MemStallM high 4 cycles per access; RD=0xDEADBEEF in DONE.
- SB 0x80 to 0x13, then LB 0x13 -> RD=0xFFFFFF80; LBU 0x13 -> RD=0x00000080; other bytes of word 0x10 unchanged.
- WAIT_CYCLES=0: back-to-back LW requests -> stall 2 cycles each, one-cycle DONE between them, no request dropped.
- rst_n low in 2nd BUSY cycle of SW 0x1 to 0x20 -> FSM IDLE immediately; later LW 0x20 returns prior contents.
- MemReqM dropped and ALUResultM changed mid-BUSY -> access completes on the captured address.
- With MISALIGN_TRAP_EN defined: SH to 0x21 -> MisalignM=1 for one cycle, memory unchanged. Without it: SH to 0x21 writes the halfword at 0x20.
